// File: rtl/mmu_rsp_arbiter.sv
// mmu_rsp_arbiter: merges the alloc and free response FIFOs of mmu_top into a
// single valid/ready response stream. It absorbs the one-cycle FIFO read
// latency, arbitrates round-robin between the two sides, and keeps saturating
// counters of accepted failed responses.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no response in flight; pop the granted side if any is non-empty
// WAIT  | a pop was issued last cycle; capture FIFO read data of side sel
// HOLD  | rsp_valid high; outputs frozen until the host asserts rsp_ready
module mmu_rsp_arbiter #(
    parameter int REQ_ID_WIDTH       = 13,
    parameter int ALL_PAGE_IDX_WIDTH = 15,
    parameter int FAIL_REASON_WIDTH  = 2,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          alloc_rsp_fifo_not_empty,
    output logic                          alloc_rsp_pop,
    input  logic [REQ_ID_WIDTH-1:0]       alloc_rsp_id,
    input  logic [ALL_PAGE_IDX_WIDTH-1:0] alloc_rsp_page_idx,
    input  logic                          alloc_rsp_fail,
    input  logic [FAIL_REASON_WIDTH-1:0]  alloc_rsp_fail_reason,

    input  logic                          free_rsp_fifo_not_empty,
    output logic                          free_rsp_pop,
    input  logic [REQ_ID_WIDTH-1:0]       free_rsp_id,
    input  logic                          free_rsp_fail,
    input  logic [FAIL_REASON_WIDTH-1:0]  free_rsp_fail_reason,

    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_type,
    output logic [REQ_ID_WIDTH-1:0]       rsp_id,
    output logic [ALL_PAGE_IDX_WIDTH-1:0] rsp_page_idx,
    output logic                          rsp_fail,
    output logic [FAIL_REASON_WIDTH-1:0]  rsp_fail_reason,

    output logic [CNT_WIDTH-1:0]          alloc_fail_cnt,
    output logic [CNT_WIDTH-1:0]          free_fail_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Response side encoding shared by sel, last_grant and rsp_type.
    localparam logic SIDE_ALLOC = 1'b0;
    localparam logic SIDE_FREE  = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                          state_q, state_d;
    logic                            last_grant_q, last_grant_d;
    logic                            sel_q, sel_d;
    logic                            rsp_valid_q, rsp_valid_d;
    logic                            rsp_type_q, rsp_type_d;
    logic [REQ_ID_WIDTH-1:0]         rsp_id_q, rsp_id_d;
    logic [ALL_PAGE_IDX_WIDTH-1:0]   rsp_page_idx_q, rsp_page_idx_d;
    logic                            rsp_fail_q, rsp_fail_d;
    logic [FAIL_REASON_WIDTH-1:0]    rsp_fail_reason_q, rsp_fail_reason_d;
    logic [CNT_WIDTH-1:0]            alloc_fail_cnt_q, alloc_fail_cnt_d;
    logic [CNT_WIDTH-1:0]            free_fail_cnt_q, free_fail_cnt_d;

    logic grant_any;
    logic grant_side;
    logic pop_allowed;
    logic pop_fire;
    logic handshake;

    // Round-robin grant and Mealy pop generation. The FIFO flags are only
    // looked at in IDLE and HOLD; in WAIT the flag may still reflect the entry
    // just popped, so no pop is allowed there.
    always_comb begin
        grant_any = alloc_rsp_fifo_not_empty | free_rsp_fifo_not_empty;
        if (alloc_rsp_fifo_not_empty && free_rsp_fifo_not_empty) begin
            grant_side = ~last_grant_q;
        end else if (free_rsp_fifo_not_empty) begin
            grant_side = SIDE_FREE;
        end else begin
            grant_side = SIDE_ALLOC;
        end

        pop_allowed = 1'b0;
        case (state_q)
            ST_IDLE: pop_allowed = 1'b1;
            ST_HOLD: pop_allowed = rsp_ready;
            default: pop_allowed = 1'b0;
        endcase

        pop_fire      = rst_n & pop_allowed & grant_any;
        alloc_rsp_pop = pop_fire & (grant_side == SIDE_ALLOC);
        free_rsp_pop  = pop_fire & (grant_side == SIDE_FREE);
    end

    // Next-state logic: sequencing, output capture and grant bookkeeping.
    always_comb begin
        state_d           = state_q;
        last_grant_d      = last_grant_q;
        sel_d             = sel_q;
        rsp_valid_d       = rsp_valid_q;
        rsp_type_d        = rsp_type_q;
        rsp_id_d          = rsp_id_q;
        rsp_page_idx_d    = rsp_page_idx_q;
        rsp_fail_d        = rsp_fail_q;
        rsp_fail_reason_d = rsp_fail_reason_q;

        case (state_q)
            ST_IDLE: begin
                if (pop_fire) begin
                    sel_d        = grant_side;
                    last_grant_d = grant_side;
                    state_d      = ST_WAIT;
                end
            end

            ST_WAIT: begin
                rsp_valid_d = 1'b1;
                rsp_type_d  = sel_q;
                if (sel_q == SIDE_FREE) begin
                    rsp_id_d          = free_rsp_id;
                    rsp_page_idx_d    = '0;
                    rsp_fail_d        = free_rsp_fail;
                    rsp_fail_reason_d = free_rsp_fail_reason;
                end else begin
                    rsp_id_d          = alloc_rsp_id;
                    rsp_page_idx_d    = alloc_rsp_page_idx;
                    rsp_fail_d        = alloc_rsp_fail;
                    rsp_fail_reason_d = alloc_rsp_fail_reason;
                end
                state_d = ST_HOLD;
            end

            ST_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (pop_fire) begin
                        sel_d        = grant_side;
                        last_grant_d = grant_side;
                        state_d      = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Saturating failure counters, bumped on each accepted failed response.
    always_comb begin
        alloc_fail_cnt_d = alloc_fail_cnt_q;
        free_fail_cnt_d  = free_fail_cnt_q;
        handshake        = rsp_valid_q & rsp_ready;

        if (handshake && rsp_fail_q) begin
            if (rsp_type_q == SIDE_FREE) begin
                if (free_fail_cnt_q != CNT_MAX) begin
                    free_fail_cnt_d = free_fail_cnt_q + CNT_ONE;
                end
            end else begin
                if (alloc_fail_cnt_q != CNT_MAX) begin
                    alloc_fail_cnt_d = alloc_fail_cnt_q + CNT_ONE;
                end
            end
        end
    end

    // State and output registers; reset leaves last_grant on the free side so
    // alloc wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            last_grant_q      <= SIDE_FREE;
            sel_q             <= SIDE_ALLOC;
            rsp_valid_q       <= 1'b0;
            rsp_type_q        <= 1'b0;
            rsp_id_q          <= '0;
            rsp_page_idx_q    <= '0;
            rsp_fail_q        <= 1'b0;
            rsp_fail_reason_q <= '0;
            alloc_fail_cnt_q  <= '0;
            free_fail_cnt_q   <= '0;
        end else begin
            state_q           <= state_d;
            last_grant_q      <= last_grant_d;
            sel_q             <= sel_d;
            rsp_valid_q       <= rsp_valid_d;
            rsp_type_q        <= rsp_type_d;
            rsp_id_q          <= rsp_id_d;
            rsp_page_idx_q    <= rsp_page_idx_d;
            rsp_fail_q        <= rsp_fail_d;
            rsp_fail_reason_q <= rsp_fail_reason_d;
            alloc_fail_cnt_q  <= alloc_fail_cnt_d;
            free_fail_cnt_q   <= free_fail_cnt_d;
        end
    end

    assign rsp_valid       = rsp_valid_q;
    assign rsp_type        = rsp_type_q;
    assign rsp_id          = rsp_id_q;
    assign rsp_page_idx    = rsp_page_idx_q;
    assign rsp_fail        = rsp_fail_q;
    assign rsp_fail_reason = rsp_fail_reason_q;
    assign alloc_fail_cnt  = alloc_fail_cnt_q;
    assign free_fail_cnt   = free_fail_cnt_q;

endmodule

// File: tb/tb_mmu_rsp_arbiter.sv
// Testbench for mmu_rsp_arbiter: behavioural response FIFOs with one-cycle
// read latency, a scoreboard of expected responses filled by the stimulus,
// and a monitor that checks every handshake against it.
module tb_mmu_rsp_arbiter;

    localparam int IW = 13;
    localparam int PW = 15;
    localparam int RW = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alloc_rsp_fifo_not_empty;
    logic          alloc_rsp_pop;
    logic [IW-1:0] alloc_rsp_id;
    logic [PW-1:0] alloc_rsp_page_idx;
    logic          alloc_rsp_fail;
    logic [RW-1:0] alloc_rsp_fail_reason;
    logic          free_rsp_fifo_not_empty;
    logic          free_rsp_pop;
    logic [IW-1:0] free_rsp_id;
    logic          free_rsp_fail;
    logic [RW-1:0] free_rsp_fail_reason;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_type;
    logic [IW-1:0] rsp_id;
    logic [PW-1:0] rsp_page_idx;
    logic          rsp_fail;
    logic [RW-1:0] rsp_fail_reason;
    logic [CW-1:0] alloc_fail_cnt;
    logic [CW-1:0] free_fail_cnt;

    always #5 clk = ~clk;

    mmu_rsp_arbiter #(
        .REQ_ID_WIDTH      (IW),
        .ALL_PAGE_IDX_WIDTH(PW),
        .FAIL_REASON_WIDTH (RW),
        .CNT_WIDTH         (CW)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .alloc_rsp_fifo_not_empty(alloc_rsp_fifo_not_empty),
        .alloc_rsp_pop           (alloc_rsp_pop),
        .alloc_rsp_id            (alloc_rsp_id),
        .alloc_rsp_page_idx      (alloc_rsp_page_idx),
        .alloc_rsp_fail          (alloc_rsp_fail),
        .alloc_rsp_fail_reason   (alloc_rsp_fail_reason),
        .free_rsp_fifo_not_empty (free_rsp_fifo_not_empty),
        .free_rsp_pop            (free_rsp_pop),
        .free_rsp_id             (free_rsp_id),
        .free_rsp_fail           (free_rsp_fail),
        .free_rsp_fail_reason    (free_rsp_fail_reason),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_type                (rsp_type),
        .rsp_id                  (rsp_id),
        .rsp_page_idx            (rsp_page_idx),
        .rsp_fail                (rsp_fail),
        .rsp_fail_reason         (rsp_fail_reason),
        .alloc_fail_cnt          (alloc_fail_cnt),
        .free_fail_cnt           (free_fail_cnt)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int a_pops = 0;
    int f_pops = 0;

    logic [IW+PW+RW:0] aq[$];     // {id, page, fail, reason}
    logic [IW+RW:0]    fq[$];     // {id, fail, reason}
    logic [31:0]       exp_q[$];  // {type, id, page, fail, reason}
    int                hs_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [IW-1:0] id, input logic [PW-1:0] pg,
                          input logic fl, input logic [RW-1:0] rs);
        aq.push_back({id, pg, fl, rs});
        exp_q.push_back({1'b0, id, pg, fl, rs});
    endtask

    task automatic push_f(input logic [IW-1:0] id, input logic fl, input logic [RW-1:0] rs);
        fq.push_back({id, fl, rs});
        exp_q.push_back({1'b1, id, {PW{1'b0}}, fl, rs});
    endtask

    // Behavioural FIFOs: pop at an edge yields data for the following cycle;
    // the not-empty flags are registered, as in mmu_top.
    always @(posedge clk) begin
        logic [IW+PW+RW:0] ta;
        logic [IW+RW:0]    tf;
        cyc++;
        if (!rst_n) begin
            aq.delete();
            fq.delete();
            alloc_rsp_fifo_not_empty <= 1'b0;
            free_rsp_fifo_not_empty  <= 1'b0;
        end else begin
            if (alloc_rsp_pop && aq.size() > 0) begin
                ta = aq.pop_front();
                {alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason} <= ta;
                a_pops++;
            end
            if (free_rsp_pop && fq.size() > 0) begin
                tf = fq.pop_front();
                {free_rsp_id, free_rsp_fail, free_rsp_fail_reason} <= tf;
                f_pops++;
            end
            alloc_rsp_fifo_not_empty <= (aq.size() != 0);
            free_rsp_fifo_not_empty  <= (fq.size() != 0);
        end
    end

    // Monitor: pop legality every cycle, and every handshake against the
    // scoreboard, sampled late in the low clock phase.
    always @(negedge clk) begin
        logic [31:0] e;
        #3;
        if (rst_n) begin
            chk("pop_onehot", {31'd0, alloc_rsp_pop & free_rsp_pop}, 32'd0);
            chk("pop_when_empty",
                {31'd0, (alloc_rsp_pop & ~alloc_rsp_fifo_not_empty) |
                        (free_rsp_pop & ~free_rsp_fifo_not_empty)}, 32'd0);
            if (rsp_valid && rsp_ready) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_handshake: got id 0x%0h type %0d expected none",
                             rsp_id, rsp_type);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", {rsp_type, rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason}, e);
                end
            end
        end
    end

    task automatic wait_idle(input int max_cyc, input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            @(negedge clk);
            #4;
            if (exp_q.size() == 0 && !rsp_valid && aq.size() == 0 && fq.size() == 0)
                done = 1'b1;
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        hs_cyc.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int hs0;
        logic [IW-1:0] id0;
        bit stable;

        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_outs", {rsp_type, rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason}, 32'd0);
        chk("rst_pops", {30'd0, alloc_rsp_pop, free_rsp_pop}, 32'd0);
        chk("rst_cnts", {16'd0, alloc_fail_cnt, free_fail_cnt}, 32'd0);
        rst_n = 1'b1;

        // Single alloc: pop at T, valid at T+2, one handshake.
        @(negedge clk);
        rsp_ready = 1'b1;
        p0 = a_pops + f_pops;
        push_a(13'h005, 15'h0123, 1'b0, 2'd0);
        @(negedge clk); #1;
        chk("t1_pop_T", {31'd0, alloc_rsp_pop}, 32'd1);
        @(negedge clk); #1;
        chk("t1_valid_T1", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk); #1;
        chk("t1_valid_T2", {31'd0, rsp_valid}, 32'd1);
        wait_idle(20, "t1_drain");
        repeat (3) @(negedge clk);
        chk("t1_pops", a_pops + f_pops - p0, 32'd1);
        chk("t1_hs", hs_cyc.size(), 32'd1);

        // Tie arbitration: alternating types, handshake every 2 cycles.
        do_reset();
        rsp_ready = 1'b1;
        p0 = a_pops + f_pops;
        for (int i = 0; i < 3; i++) begin
            push_a(IW'(13'h010 + i), PW'(15'h0200 + i), 1'b0, 2'd0);
            push_f(IW'(13'h020 + i), 1'b0, 2'd1);
        end
        wait_idle(60, "t2_drain");
        chk("t2_hs", hs_cyc.size(), 32'd6);
        for (int i = 1; i < hs_cyc.size(); i++)
            chk("t2_interval", hs_cyc[i] - hs_cyc[i-1], 32'd2);
        chk("t2_pops", a_pops + f_pops - p0, 32'd6);

        // Backpressure: stall 10 cycles, then pop in the cycle ready rises.
        do_reset();
        rsp_ready = 1'b0;
        p0 = a_pops + f_pops;
        push_a(13'h031, 15'h0301, 1'b0, 2'd0);
        push_f(13'h041, 1'b0, 2'd0);
        push_a(13'h032, 15'h0302, 1'b0, 2'd0);
        push_f(13'h042, 1'b0, 2'd0);
        repeat (3) @(negedge clk);
        #1;
        id0 = rsp_id;
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (!rsp_valid || rsp_id !== id0 || rsp_type !== 1'b0) stable = 1'b0;
        end
        chk("t3_stable", {31'd0, stable}, 32'd1);
        chk("t3_id", {19'd0, rsp_id}, 32'h31);
        chk("t3_pops_stalled", a_pops + f_pops - p0, 32'd1);
        rsp_ready = 1'b1;
        #1;
        chk("t3_pop_on_ready", {31'd0, free_rsp_pop}, 32'd1);
        wait_idle(40, "t3_drain");
        chk("t3_pops", a_pops + f_pops - p0, 32'd4);

        // Free response with failure.
        do_reset();
        rsp_ready = 1'b1;
        push_f(13'h1FFF, 1'b1, 2'd2);
        wait_idle(20, "t4_drain");
        chk("t4_free_cnt", {24'd0, free_fail_cnt}, 32'd1);
        chk("t4_alloc_cnt", {24'd0, alloc_fail_cnt}, 32'd0);

        // Counter saturation (8-bit counter instance).
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 254; i++) push_a(IW'(i), PW'(i), 1'b1, 2'd1);
        wait_idle(700, "t5_drain_a");
        chk("t5_cnt_fe", {24'd0, alloc_fail_cnt}, 32'hFE);
        for (int i = 0; i < 3; i++) push_a(IW'(13'h100 + i), PW'(i), 1'b1, 2'd3);
        wait_idle(30, "t5_drain_b");
        chk("t5_cnt_sat", {24'd0, alloc_fail_cnt}, 32'hFF);
        chk("t5_free_cnt", {24'd0, free_fail_cnt}, 32'd0);

        // Reset asserted in the WAIT cycle discards the popped entry.
        @(negedge clk);
        push_a(13'h077, 15'h0777, 1'b1, 2'd3);
        @(negedge clk); #1;
        chk("t6_pop", {31'd0, alloc_rsp_pop}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk); #1;
        chk("t6_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t6_cnts", {16'd0, alloc_fail_cnt, free_fail_cnt}, 32'd0);
        rst_n = 1'b1;
        hs0 = hs_cyc.size();
        repeat (8) @(negedge clk);
        #4;
        chk("t6_no_hs", hs_cyc.size() - hs0, 32'd0);
        chk("t6_valid_after", {31'd0, rsp_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmu_rsp_arbiter.md
# mmu_rsp_arbiter

Merges the two response queues of `mmu_top` into one valid/ready response stream for the host. It sits directly downstream of `mmu_top` and drives `alloc_rsp_pop` and `free_rsp_pop` from the `*_rsp_fifo_not_empty` flags. It absorbs the one-cycle FIFO read latency, arbitrates round-robin between alloc and free responses, and keeps saturating failure counters.

## Interface
Parameters:
- `REQ_ID_WIDTH`, 13, response id width
- `ALL_PAGE_IDX_WIDTH`, 15, page index width
- `FAIL_REASON_WIDTH`, 2, fail reason width
- `CNT_WIDTH`, 16, failure counter width

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `alloc_rsp_fifo_not_empty`  in  1  alloc response available.
- `alloc_rsp_pop`  out  1  pop; data is valid on the next cycle.
- `alloc_rsp_id`  in  REQ_ID_WIDTH  alloc response id.
- `alloc_rsp_page_idx`  in  ALL_PAGE_IDX_WIDTH  allocated page index.
- `alloc_rsp_fail`  in  1  alloc failed.
- `alloc_rsp_fail_reason`  in  FAIL_REASON_WIDTH  alloc fail reason.
- `free_rsp_fifo_not_empty`  in  1  free response available.
- `free_rsp_pop`  out  1  pop; data is valid on the next cycle.
- `free_rsp_id`  in  REQ_ID_WIDTH  free response id.
- `free_rsp_fail`  in  1  free failed.
- `free_rsp_fail_reason`  in  FAIL_REASON_WIDTH  free fail reason.
- `rsp_valid`  out  1  merged response valid.
- `rsp_ready`  in  1  host accepts the response.
- `rsp_type`  out  1  0 = alloc, 1 = free.
- `rsp_id`  out  REQ_ID_WIDTH  response id.
- `rsp_page_idx`  out  ALL_PAGE_IDX_WIDTH  page index; 0 for free responses.
- `rsp_fail`  out  1  failure flag.
- `rsp_fail_reason`  out  FAIL_REASON_WIDTH  failure reason.
- `alloc_fail_cnt`  out  CNT_WIDTH  accepted failed alloc responses.
- `free_fail_cnt`  out  CNT_WIDTH  accepted failed free responses.

## Operation
- The FSM has three states: IDLE, WAIT, HOLD.
- **Grant rule:**
  - If only one `*_not_empty` is high, that side is granted.
  - If both are high, the side opposite `last_grant` is granted.
  - `last_grant` updates on every grant.
- **Pop:** a pop is a combinational Mealy output of the grant.
  - In IDLE, it is issued whenever any `not_empty` is high.
  - In HOLD, it is issued only when `rsp_ready` is also high.
  - At most one pop is high per cycle.
  - A pop is never issued in WAIT.
  - A pop is never issued for a side whose `not_empty` is low.
- **IDLE:** on a grant, pop the granted side, latch `sel`, and go to WAIT. With no grant, stay in IDLE.
- **WAIT:**
  - Capture the FIFO read data of side `sel` into the output registers.
  - Set `rsp_type = sel`.
  - For free responses, force `rsp_page_idx` to 0.
  - Set `rsp_valid <= 1` and go to HOLD.
- **HOLD:** `rsp_valid` stays 1 and the outputs are stable until `rsp_ready`.
  - On `rsp_ready` with a grant: pop, go to WAIT, and `rsp_valid <= 0`.
  - On `rsp_ready` without a grant: go to IDLE and `rsp_valid <= 0`.
- **Counters:** on each handshake (`rsp_valid & rsp_ready`) with `rsp_fail = 1`, increment `alloc_fail_cnt` or `free_fail_cnt` according to `rsp_type`. Counters saturate at all-ones.
- **Overflow:** no responses are dropped or duplicated. Each pop yields exactly one `rsp_valid` handshake.
- **Reset:** a synchronous reset in WAIT discards the popped entry. This is acceptable because the `mmu_top` FIFOs share `rst_n`.

## Timing
- **Reset values:**
  - State is IDLE and `last_grant = 1` (free), so alloc wins the first tie.
  - `rsp_valid`, `rsp_type`, `rsp_id`, `rsp_page_idx`, `rsp_fail` and `rsp_fail_reason` are 0.
  - Both pops are 0 and both counters are 0.
  - During reset, pops are forced to 0.
- **Latency:** `rsp_valid` rises 2 cycles after the cycle in which `not_empty` is seen high in IDLE (pop at T, capture at T+1, valid from T+2).
- **Throughput:** one response every 2 cycles with `rsp_ready` held high.
- **`not_empty` sampling:** `not_empty` is sampled only in IDLE or HOLD. A pop issued at T is reflected in the flag by T+1, and WAIT at T+1 ignores it.
- **Held `rsp_ready`:** `rsp_ready` high while `rsp_valid` is low has no effect.
- **Stalled host:** with `rsp_ready` low, the block holds indefinitely and issues no further pops.

## Test plan
- **Single alloc:** after reset, alloc FIFO holds {id 0x005, page 0x0123, fail 0} and `rsp_ready` = 1. Expect: pop at T, `rsp_valid` at T+2 with type 0, id 0x005, page 0x0123; one handshake; no further pops.
- **Tie arbitration:** both FIFOs hold 3 entries each and `rsp_ready` = 1. Expect: types in the order 0,1,0,1,0,1; a handshake every 2 cycles; 6 pops total.
- **Backpressure:** `rsp_ready` = 0 for 10 cycles with both FIFOs non-empty. Expect: `rsp_valid` and outputs stable; exactly one pop over the period; after `rsp_ready` rises, the next pop occurs in the same cycle.
- **Free response:** free response {id 0x1FFF, fail 1, reason 2}. Expect: type 1, id 0x1FFF, page 0, fail 1, reason 2; `free_fail_cnt` = 1 and `alloc_fail_cnt` = 0 after the handshake.
- **Counter saturation:** preload 65 537 failed alloc responses (or force the counter to 0xFFFE, then send 3). Expect: `alloc_fail_cnt` saturates at 0xFFFF and does not wrap.
- **Reset mid-flight:** `rst_n` = 0 in the WAIT cycle. Expect: next cycle state is IDLE, `rsp_valid` = 0 and counters = 0; no spurious handshake after reset release.
